// File: rtl/pipelined_prefix_adder.sv
// Pipelined Sklansky-style parallel-prefix adder/subtractor with a valid/ready stream interface.
// STAGES register banks sit between input accept and the flopped outputs.
module pipelined_prefix_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned Levels = $clog2(WIDTH);

  // Bit k set: a register bank sits after prefix level k (k=0 is operand prep).
  // The bank after the last level is always present and drives the outputs.
  function automatic logic [Levels:0] cut_mask();
    logic [Levels:0] m;
    m = {1'b1, {Levels{1'b0}}};
    if (STAGES > 1) begin
      for (int unsigned b = 0; b < STAGES - 1; b++) begin
        m = m | ({{Levels{1'b0}}, 1'b1} << ((b * Levels + STAGES - 2) / (STAGES - 1)));
      end
    end
    return m;
  endfunction

  localparam logic [Levels:0] Cut = cut_mask();

  // One Sklansky level: bits with bit (lvl-1) set combine with the top bit of the lower block.
  function automatic logic [2*WIDTH-1:0] prefix_level(input logic [WIDTH-1:0] g_in,
                                                      input logic [WIDTH-1:0] p_in,
                                                      input int unsigned      lvl);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    int unsigned      span;
    int unsigned      j;
    g    = g_in;
    p    = p_in;
    span = 1 << (lvl - 1);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if ((i & span) != 0) begin
        j    = (i & ~(span - 1)) - 1;
        g[i] = g[i] | (p[i] & g[j]);
        p[i] = p[i] & p[j];
      end
    end
    return {g, p};
  endfunction

  logic [WIDTH-1:0] g_q  [0:Levels-1];
  logic [WIDTH-1:0] p_q  [0:Levels-1];
  logic [WIDTH-1:0] h_q  [0:Levels-1];
  logic             ci_q [0:Levels-1];
  logic             v_q  [0:Levels-1];
  logic [WIDTH-1:0] g_d  [0:Levels-1];
  logic [WIDTH-1:0] p_d  [0:Levels-1];
  logic [WIDTH-1:0] h_d  [0:Levels-1];
  logic             ci_d [0:Levels-1];
  logic             v_d  [0:Levels-1];

  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;
  logic               stall;

  logic [WIDTH-1:0]   bb;
  logic [WIDTH-1:0]   cur_g, cur_p, cur_h;
  logic               cur_ci, cur_v;
  logic [2*WIDTH-1:0] gp;

  assign stall     = valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

  always_comb begin
    gp     = '0;
    bb     = in_sub ? ~in_b : in_b;
    cur_ci = in_cin ^ in_sub;
    cur_h  = in_a ^ bb;
    cur_g  = in_a & bb;
    // Carry-in folded into bit 0 so the tree yields c_i = G[i:0] directly.
    cur_g[0] = cur_g[0] | (cur_h[0] & cur_ci);
    cur_p  = cur_h;
    cur_v  = in_valid;
    for (int k = 0; k < Levels; k++) begin
      if (k > 0) begin
        gp    = prefix_level(cur_g, cur_p, k);
        cur_g = gp[2*WIDTH-1:WIDTH];
        cur_p = gp[WIDTH-1:0];
      end
      g_d[k]  = cur_g;
      p_d[k]  = cur_p;
      h_d[k]  = cur_h;
      ci_d[k] = cur_ci;
      v_d[k]  = cur_v;
      if (Cut[k]) begin
        cur_g  = g_q[k];
        cur_p  = p_q[k];
        cur_h  = h_q[k];
        cur_ci = ci_q[k];
        cur_v  = v_q[k];
      end
    end
    gp      = prefix_level(cur_g, cur_p, Levels);
    cur_g   = gp[2*WIDTH-1:WIDTH];
    sum_d   = cur_h ^ {cur_g[WIDTH-2:0], cur_ci};
    cout_d  = cur_g[WIDTH-1];
    ovf_d   = cur_g[WIDTH-1] ^ cur_g[WIDTH-2];
    valid_d = cur_v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < Levels; k++) begin
        g_q[k]  <= '0;
        p_q[k]  <= '0;
        h_q[k]  <= '0;
        ci_q[k] <= 1'b0;
        v_q[k]  <= 1'b0;
      end
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < Levels; k++) begin
        if (Cut[k]) begin
          v_q[k] <= v_d[k];
          // Bubbles advance only their valid bit; data regs keep the last beat.
          if (v_d[k]) begin
            g_q[k]  <= g_d[k];
            p_q[k]  <= p_d[k];
            h_q[k]  <= h_d[k];
            ci_q[k] <= ci_d[k];
          end
        end
      end
      valid_q <= valid_d;
      if (valid_d) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Scoreboard bench: a 32-bit/2-stage instance for directed vectors and backpressure,
// an 8-bit/max-stage instance for a random model sweep and mid-flight reset.
module tb_pipelined_prefix_adder;

  localparam int unsigned W  = 32;
  localparam int unsigned BW = 8;
  localparam int unsigned BS = $clog2(BW) + 1;
  localparam int unsigned NB = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst, a_in_valid, a_in_ready, a_in_cin, a_in_sub;
  logic          a_out_valid, a_out_ready, a_out_cout, a_out_ovf;
  logic [W-1:0]  a_in_a, a_in_b, a_out_sum;
  logic          b_rst, b_in_valid, b_in_ready, b_in_cin, b_in_sub;
  logic          b_out_valid, b_out_ready, b_out_cout, b_out_ovf;
  logic [BW-1:0] b_in_a, b_in_b, b_out_sum;

  pipelined_prefix_adder #(.WIDTH(W), .STAGES(2)) dut_a (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_a(a_in_a), .in_b(a_in_b), .in_cin(a_in_cin), .in_sub(a_in_sub),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum),
    .out_cout(a_out_cout), .out_ovf(a_out_ovf)
  );

  pipelined_prefix_adder #(.WIDTH(BW), .STAGES(BS)) dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a(b_in_a), .in_b(b_in_b), .in_cin(b_in_cin), .in_sub(b_in_sub),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
    .out_cout(b_out_cout), .out_ovf(b_out_ovf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected beats are packed {cout, ovf, sum}.
  logic [W+1:0]  a_exp;
  logic [W+1:0]  a_q[$];
  logic [BW+1:0] b_exp;
  logic [BW+1:0] b_q[$];
  logic          b_took = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [BW+1:0] model8(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                          input logic cin, input logic sub);
    logic [BW-1:0] bb;
    logic [BW:0]   full;
    logic          ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{BW{1'b0}}, cin ^ sub};
    ovf  = (a[BW-1] == bb[BW-1]) && (full[BW-1] != a[BW-1]);
    return {full[BW], ovf, full[BW-1:0]};
  endfunction

  // Monitors: push at accept, pop-and-compare at emit, both sampled on the falling edge.
  always @(negedge clk) begin
    if (!a_rst) begin
      if (a_in_valid && a_in_ready) a_q.push_back(a_exp);
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) check("a_unexpected_beat", 64'd1, 64'd0);
        else check("a_result", {a_out_cout, a_out_ovf, a_out_sum}, a_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    b_took = b_in_valid && b_in_ready && !b_rst;
    if (!b_rst) begin
      if (b_in_valid && b_in_ready) b_q.push_back(b_exp);
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) check("b_unexpected_beat", 64'd1, 64'd0);
        else check("b_result", {b_out_cout, b_out_ovf, b_out_sum}, b_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_a(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [W+1:0] exp);
    int waited;
    a_in_a = a; a_in_b = b; a_in_cin = cin; a_in_sub = sub; a_exp = exp;
    a_in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!a_in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 50) check("a_in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int cyc = 0;
    while (a_q.size() != 0 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check("a_drain", a_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic drain_b();
    int cyc = 0;
    while (b_q.size() != 0 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("b_drain", b_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int sent;
    int cyc;
    a_rst = 1'b1; a_in_valid = 1'b0; a_in_a = '0; a_in_b = '0; a_in_cin = 1'b0;
    a_in_sub = 1'b0; a_out_ready = 1'b1; a_exp = '0;
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_a = '0; b_in_b = '0; b_in_cin = 1'b0;
    b_in_sub = 1'b0; b_out_ready = 1'b1; b_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    a_rst = 1'b0;
    b_rst = 1'b0;

    check("a_reset_ready", a_in_ready, 1);
    check("a_reset_valid", a_out_valid, 0);
    check("a_reset_outs", {a_out_cout, a_out_ovf, a_out_sum}, 0);

    // All-ones + carry-in wraps to zero; result one cycle after accept.
    send_a(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, {1'b1, 1'b0, 32'h0000_0000});
    check("a_latency_early", a_out_valid, 0);
    @(posedge clk); #1;
    check("a_latency", a_out_valid, 1);
    drain_a();

    send_a(32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, {1'b0, 1'b1, 32'h8000_0000});
    send_a(32'h8000_0000, 32'h1,         1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
    send_a(32'h5,         32'h7,         1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
    send_a(32'h5,         32'h5,         1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFF});
    send_a(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, {1'b1, 1'b1, 32'h0000_0000});
    send_a(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, {1'b0, 1'b0, 32'h2345_678A});
    send_a(32'h0,         32'h1,         1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFF});
    send_a(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, {1'b0, 1'b1, 32'h8000_0000});
    send_a(32'hA,         32'h3,         1'b1, 1'b1, {1'b1, 1'b0, 32'h0000_0006});
    drain_a();

    // Full-rate burst of 8 with a 3-cycle output stall while beat 2 is presented.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send_a(W'(i), W'(i), 1'b0, 1'b0, {2'b00, W'(2 * i)});
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("a_stall_in_ready", a_in_ready, 0);
          check("a_stall_valid", a_out_valid, 1);
          check("a_stall_sum", a_out_sum, 4);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        repeat (6) begin
          @(negedge clk);
          check("a_no_gap", a_out_valid, 1);
        end
      end
    join
    drain_a();

    // Random sweep on the narrow, fully pipelined instance.
    sent = 0;
    cyc  = 0;
    while (cyc < 20000) begin
      @(posedge clk); #1; cyc++;
      b_out_ready = ($urandom_range(0, 3) != 0);
      if (!b_in_valid || b_took) begin
        if (sent < NB && $urandom_range(0, 3) != 0) begin
          b_in_a   = BW'($urandom);
          b_in_b   = BW'($urandom);
          b_in_cin = 1'($urandom);
          b_in_sub = 1'($urandom);
          b_exp    = model8(b_in_a, b_in_b, b_in_cin, b_in_sub);
          b_in_valid = 1'b1;
          sent++;
        end else begin
          b_in_valid = 1'b0;
        end
      end
      if (sent == NB && !b_in_valid) break;
    end
    check("b_random_budget", cyc < 20000, 1);
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    drain_b();

    b_in_a = 8'h40; b_in_b = 8'h01; b_in_cin = 1'b0; b_in_sub = 1'b0;
    b_exp = {2'b00, 8'h41};
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    drain_b();

    // Two beats in flight, then a one-cycle reset: neither may emerge.
    b_in_a = 8'h01; b_in_b = 8'h02; b_exp = {2'b00, 8'h03};
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_a = 8'h03; b_in_b = 8'h04; b_exp = {2'b00, 8'h07};
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_rst = 1'b1;
    @(posedge clk); #1;
    b_rst = 1'b0;
    b_q.delete();
    check("b_rst_valid", b_out_valid, 0);
    check("b_rst_sum", b_out_sum, 0);
    check("b_rst_ready", b_in_ready, 1);
    repeat (6) begin
      @(negedge clk);
      check("b_rst_no_emit", b_out_valid, 0);
    end

    check("a_queue_empty", a_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
